// File: rtl/rename_unit_param_if.sv
// Decode/dispatch/ROB-facing signal bundle of the rename stage.
// The master side drives instructions, commits and flush; the slave side is the rename unit.
interface rename_unit_param_if #(
    parameter int unsigned NUM_ARCH = 8,
    parameter int unsigned NUM_PHYS = 32
);
    localparam int unsigned AW = $clog2(NUM_ARCH);
    localparam int unsigned PW = $clog2(NUM_PHYS);

    logic          ren_valid;
    logic          ren_ready;
    logic          ren_has_dest;
    logic [AW-1:0] ren_dest;
    logic [AW-1:0] ren_sr1;
    logic [AW-1:0] ren_sr2;

    logic          out_valid;
    logic [PW-1:0] out_sr1;
    logic [PW-1:0] out_sr2;
    logic [PW-1:0] out_dest;
    logic [PW-1:0] out_prev;

    logic          commit_valid;
    logic          commit_has_dest;
    logic [AW-1:0] commit_arch;
    logic [PW-1:0] commit_phys;
    logic [PW-1:0] commit_prev;

    logic          flush;
    logic [PW:0]   free_count;

    modport master (
        output ren_valid, ren_has_dest, ren_dest, ren_sr1, ren_sr2,
        output commit_valid, commit_has_dest, commit_arch, commit_phys, commit_prev, flush,
        input  ren_ready, out_valid, out_sr1, out_sr2, out_dest, out_prev, free_count
    );

    modport slave (
        input  ren_valid, ren_has_dest, ren_dest, ren_sr1, ren_sr2,
        input  commit_valid, commit_has_dest, commit_arch, commit_phys, commit_prev, flush,
        output ren_ready, out_valid, out_sr1, out_sr2, out_dest, out_prev, free_count
    );
endinterface

// File: rtl/rename_unit_param.sv
// Register rename stage: speculative and committed RATs, circular free list,
// single-cycle flush recovery and a one-cycle registered rename result.
module rename_unit_param #(
    parameter int unsigned NUM_ARCH = 8,
    parameter int unsigned NUM_PHYS = 32
) (
    input logic                clk,
    input logic                rst_n,
    rename_unit_param_if.slave rn_io
);
    localparam int unsigned AW      = $clog2(NUM_ARCH);
    localparam int unsigned PW      = $clog2(NUM_PHYS);
    localparam int unsigned NumFree = NUM_PHYS - NUM_ARCH;

    logic [PW-1:0] spec_rat_q [NUM_ARCH];
    logic [PW-1:0] spec_rat_d [NUM_ARCH];
    logic [PW-1:0] arch_rat_q [NUM_ARCH];
    logic [PW-1:0] arch_rat_d [NUM_ARCH];
    logic [PW-1:0] free_q     [NUM_PHYS];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW:0]   head_q, head_d;
    logic [PW:0]   commit_head_q, commit_head_d;
    logic [PW:0]   tail_q, tail_d;

    logic          out_valid_q;
    logic [PW-1:0] out_sr1_q, out_sr2_q, out_dest_q, out_prev_q;

    logic [PW:0]   free_count;
    logic          ren_ready;
    logic          accept;
    logic          alloc;
    logic          commit_fire;
    logic [PW-1:0] alloc_phys;

    assign free_count  = tail_q - head_q;
    assign ren_ready   = !rn_io.flush && (free_count != '0);
    assign accept      = rn_io.ren_valid && ren_ready;
    assign alloc       = accept && rn_io.ren_has_dest;
    assign commit_fire = rn_io.commit_valid && rn_io.commit_has_dest;
    assign alloc_phys  = free_q[head_q[PW-1:0]];

    assign rn_io.ren_ready  = ren_ready;
    assign rn_io.free_count = free_count;
    assign rn_io.out_valid  = out_valid_q;
    assign rn_io.out_sr1    = out_sr1_q;
    assign rn_io.out_sr2    = out_sr2_q;
    assign rn_io.out_dest   = out_dest_q;
    assign rn_io.out_prev   = out_prev_q;

    always_comb begin
        arch_rat_d = arch_rat_q;
        if (commit_fire) begin
            arch_rat_d[rn_io.commit_arch] = rn_io.commit_phys;
        end

        // Flush restores from the committed map including this cycle's commit.
        spec_rat_d = spec_rat_q;
        if (rn_io.flush) begin
            spec_rat_d = arch_rat_d;
        end else if (alloc) begin
            spec_rat_d[rn_io.ren_dest] = alloc_phys;
        end

        commit_head_d = commit_head_q + {{PW{1'b0}}, commit_fire};
        tail_d        = tail_q + {{PW{1'b0}}, commit_fire};
        head_d        = rn_io.flush ? commit_head_d : head_q + {{PW{1'b0}}, alloc};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_ARCH; i++) begin
                spec_rat_q[i] <= PW'(i);
                arch_rat_q[i] <= PW'(i);
            end
            for (int unsigned i = 0; i < NUM_PHYS; i++) begin
                free_q[i] <= (i < NumFree) ? PW'(i + NUM_ARCH) : '0;
            end
            head_q        <= '0;
            commit_head_q <= '0;
            tail_q        <= (PW+1)'(NumFree);
            out_valid_q   <= 1'b0;
            out_sr1_q     <= '0;
            out_sr2_q     <= '0;
            out_dest_q    <= '0;
            out_prev_q    <= '0;
        end else begin
            spec_rat_q    <= spec_rat_d;
            arch_rat_q    <= arch_rat_d;
            head_q        <= head_d;
            commit_head_q <= commit_head_d;
            tail_q        <= tail_d;
            if (commit_fire) begin
                free_q[tail_q[PW-1:0]] <= rn_io.commit_prev;
            end
            out_valid_q <= accept;
            // Sources read the map as it stood before this cycle's allocation.
            if (accept) begin
                out_sr1_q  <= spec_rat_q[rn_io.ren_sr1];
                out_sr2_q  <= spec_rat_q[rn_io.ren_sr2];
                out_prev_q <= spec_rat_q[rn_io.ren_dest];
                out_dest_q <= rn_io.ren_has_dest ? alloc_phys : '0;
            end
        end
    end
endmodule
